// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB register bank with wait states and registered response.
// Define APB_SLV_PSLVERR_EN to answer out-of-range accesses with pslverr.
module apb_slave_regfile #(
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                     pclk,
  input  logic                     presetn,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [31:0]              paddr,
  input  logic [31:0]              pwdata,
  output logic [31:0]              prdata,
  output logic                     pready,
  output logic                     pslverr,
  output logic [NUM_REGS*32-1:0]   regs_o
);
  localparam int AW = $clog2(NUM_REGS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic wr_q, wr_d, inr_q, inr_d, pready_q, pready_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0] prdata_q, prdata_d;
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];
  logic [29:0] off;
  logic unused_ok;
  assign unused_ok = ^paddr[1:0];
  assign off = paddr[31:2] - BASE_ADDR[31:2];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wr_d = wr_q;
    idx_d = idx_q;
    inr_d = inr_q;
    regs_d = regs_q;
    case (state_q)
      IDLE: if (psel && !penable) begin
        wr_d = pwrite;
        idx_d = paddr[AW+1:2];
        inr_d = off < 30'(NUM_REGS);
        cnt_d = 4'(WAIT_CYCLES);
        state_d = WAIT_CYCLES == 0 ? RESP : WAIT;
      end
      WAIT: if (!psel) state_d = IDLE;
      else if (penable) begin
        cnt_d = cnt_q - 4'd1;
        state_d = cnt_q == 4'd1 ? RESP : WAIT;
      end
      RESP: begin
        if (wr_q && inr_q && psel && penable) regs_d[idx_q] = pwdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // response flops load on entry to RESP so they are valid for the whole RESP cycle
    pready_d = state_d == RESP;
    prdata_d = (state_d == RESP && !wr_d && inr_d) ? regs_q[idx_d] : 32'h0;
  end
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wr_q <= 1'b0;
      idx_q <= '0;
      inr_q <= 1'b0;
      pready_q <= 1'b0;
      prdata_q <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      idx_q <= idx_d;
      inr_q <= inr_d;
      pready_q <= pready_d;
      prdata_q <= prdata_d;
      regs_q <= regs_d;
    end
  end
  always_comb begin
    regs_o = '0;
    for (int k = 0; k < NUM_REGS; k++) regs_o[32*k +: 32] = regs_q[k];
  end
  assign pready = pready_q;
  assign prdata = prdata_q;
`ifdef APB_SLV_PSLVERR_EN
  logic pslverr_q, pslverr_d;
  always_comb pslverr_d = state_d == RESP && !inr_d;
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) pslverr_q <= 1'b0;
    else pslverr_q <= pslverr_d;
  end
  assign pslverr = pslverr_q;
`else
  assign pslverr = 1'b0;
`endif
endmodule
